// File: rtl/vga_frame_sequencer.sv
// Frame-synchronous game register bank plus splash/playing/game-over mode sequencer.
// Define VGA_DOUBLE_BUFFER_EN to stage writes in a shadow bank committed at screen_end.
module vga_frame_sequencer #(
    parameter int unsigned NUM_REGS     = 15,
    parameter int unsigned HOLD_FRAMES  = 180,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_screen_end,
    input  logic                     i_reg_wr_en,
    input  logic [3:0]               i_reg_wr_addr,
    input  logic [31:0]              i_reg_wr_data,
    output logic [32*NUM_REGS-1:0]   o_disp_regs,
    output logic                     o_frame_commit,
    output logic [1:0]               o_mode,
    output logic                     o_score_sel,
    output logic                     o_score_visible,
    output logic                     o_dirty
);

    localparam int unsigned CNT_W = $clog2(HOLD_FRAMES) + 1;

    typedef enum logic [1:0] {
        ST_SPLASH   = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_GAMEOVER = 2'd2
    } state_t;

    logic [31:0]             r_disp [NUM_REGS];
    logic [32*NUM_REGS-1:0]  w_disp_flat;
    logic                    w_wr_hit;
    logic                    w_active_any;
    logic                    r_frame_commit;
    state_t                  r_state;
    logic [CNT_W-1:0]        r_frame_cnt;
    logic [CNT_W-1:0]        w_blink_q;
    logic                    r_score_sel;
    logic                    r_score_visible;

    assign w_wr_hit = i_reg_wr_en && (32'(i_reg_wr_addr) < NUM_REGS);

`ifdef VGA_DOUBLE_BUFFER_EN
    logic [31:0] r_shadow     [NUM_REGS];
    logic [31:0] w_shadow_nxt [NUM_REGS];
    logic        r_dirty;

    // Shadow next-state includes this cycle's write so a same-cycle commit captures it.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (w_wr_hit && (i_reg_wr_addr == 4'(i))) begin
                w_shadow_nxt[i] = i_reg_wr_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
                r_disp[i]   <= '0;
            end
            r_dirty <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_screen_end) begin
                r_disp  <= w_shadow_nxt;
                r_dirty <= 1'b0;
            end else if (w_wr_hit) begin
                r_dirty <= 1'b1;
            end
        end
    end

    assign o_dirty = r_dirty;
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_disp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit && (i_reg_wr_addr == 4'(i))) begin
                    r_disp[i] <= i_reg_wr_data;
                end
            end
        end
    end

    assign o_dirty = 1'b0;
`endif

    always_comb begin
        w_disp_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_disp_flat[32*i +: 32] = r_disp[i];
        end
    end

    assign w_active_any = |w_disp_flat;
    assign w_blink_q    = r_frame_cnt / CNT_W'(BLINK_FRAMES);

    // Mode machine steps once per commit; blink uses the count before this commit's increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_commit  <= 1'b0;
            r_state         <= ST_SPLASH;
            r_frame_cnt     <= '0;
            r_score_sel     <= 1'b1;
            r_score_visible <= 1'b1;
        end else begin
            r_frame_commit <= i_screen_end;
            if (r_frame_commit) begin
                case (r_state)
                    ST_SPLASH: begin
                        if (w_active_any) begin
                            r_state         <= ST_PLAYING;
                            r_score_sel     <= 1'b0;
                            r_score_visible <= 1'b1;
                        end
                    end
                    ST_PLAYING: begin
                        if (!w_active_any) begin
                            r_state         <= ST_GAMEOVER;
                            r_frame_cnt     <= '0;
                            r_score_sel     <= 1'b0;
                            r_score_visible <= 1'b1;
                        end
                    end
                    ST_GAMEOVER: begin
                        if (w_active_any) begin
                            r_state         <= ST_PLAYING;
                            r_score_sel     <= 1'b0;
                            r_score_visible <= 1'b1;
                        end else if (r_frame_cnt == CNT_W'(HOLD_FRAMES - 1)) begin
                            r_state         <= ST_SPLASH;
                            r_score_sel     <= 1'b1;
                            r_score_visible <= 1'b1;
                        end else begin
                            r_score_visible <= ~w_blink_q[0];
                            if (r_frame_cnt != {CNT_W{1'b1}}) begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state         <= ST_SPLASH;
                        r_score_sel     <= 1'b1;
                        r_score_visible <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_disp_regs     = w_disp_flat;
    assign o_frame_commit  = r_frame_commit;
    assign o_mode          = r_state;
    assign o_score_sel     = r_score_sel;
    assign o_score_visible = r_score_visible;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer: a cycle model pushes expected outputs, compared after each edge.
module tb_vga_frame_sequencer;

    localparam int unsigned NUM_REGS     = 15;
    localparam int unsigned HOLD_FRAMES  = 180;
    localparam int unsigned BLINK_FRAMES = 15;
    localparam int unsigned W            = 32 * NUM_REGS;

    logic         clk = 1'b0;
    logic         reset;
    logic         screen_end;
    logic         reg_wr_en;
    logic [3:0]   reg_wr_addr;
    logic [31:0]  reg_wr_data;
    logic [W-1:0] disp_regs;
    logic         frame_commit;
    logic [1:0]   mode;
    logic         score_sel;
    logic         score_visible;
    logic         dirty;

    vga_frame_sequencer #(
        .NUM_REGS    (NUM_REGS),
        .HOLD_FRAMES (HOLD_FRAMES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_screen_end   (screen_end),
        .i_reg_wr_en    (reg_wr_en),
        .i_reg_wr_addr  (reg_wr_addr),
        .i_reg_wr_data  (reg_wr_data),
        .o_disp_regs    (disp_regs),
        .o_frame_commit (frame_commit),
        .o_mode         (mode),
        .o_score_sel    (score_sel),
        .o_score_visible(score_visible),
        .o_dirty        (dirty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] regs;
        logic         commit;
        logic [1:0]   mode;
        logic         sel;
        logic         vis;
        logic         dirty;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_sh [NUM_REGS];
    logic [31:0] m_dp [NUM_REGS];
    logic        m_commit;
    logic [1:0]  m_mode;
    int          m_cnt;
    logic        m_sel;
    logic        m_vis;
    logic        m_dirty;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic step(input logic rst, input logic se, input logic we,
                        input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] n_sh [NUM_REGS];
        logic [31:0] n_dp [NUM_REGS];
        logic        act;
        logic        hit;
        logic [1:0]  n_mode;
        int          n_cnt;
        logic        n_sel;
        logic        n_vis;
        logic        n_dirty;
        exp_t        e;
        exp_t        got;

        reset       = rst;
        screen_end  = se;
        reg_wr_en   = we;
        reg_wr_addr = addr;
        reg_wr_data = data;

        hit  = we && (addr != 4'd15);
        n_sh = m_sh;
        n_dp = m_dp;
        if (hit) n_sh[addr] = data;
`ifdef VGA_DOUBLE_BUFFER_EN
        if (se) n_dp = n_sh;
        n_dirty = se ? 1'b0 : (hit ? 1'b1 : m_dirty);
`else
        if (hit) n_dp[addr] = data;
        n_dirty = 1'b0;
`endif
        act = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) if (m_dp[i] != 32'd0) act = 1'b1;

        n_mode = m_mode; n_cnt = m_cnt; n_sel = m_sel; n_vis = m_vis;
        if (m_commit) begin
            case (m_mode)
                2'd0: if (act) begin n_mode = 2'd1; n_sel = 1'b0; n_vis = 1'b1; end
                2'd1: if (!act) begin n_mode = 2'd2; n_cnt = 0; n_sel = 1'b0; n_vis = 1'b1; end
                default: begin
                    if (act) begin
                        n_mode = 2'd1; n_sel = 1'b0; n_vis = 1'b1;
                    end else if (m_cnt == HOLD_FRAMES - 1) begin
                        n_mode = 2'd0; n_sel = 1'b1; n_vis = 1'b1;
                    end else begin
                        n_vis = ((m_cnt / BLINK_FRAMES) % 2) == 0;
                        n_cnt = m_cnt + 1;
                    end
                end
            endcase
        end

        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin n_sh[i] = 32'd0; n_dp[i] = 32'd0; end
            n_mode = 2'd0; n_cnt = 0; n_sel = 1'b1; n_vis = 1'b1; n_dirty = 1'b0;
        end

        m_sh = n_sh; m_dp = n_dp;
        m_commit = rst ? 1'b0 : se;
        m_mode = n_mode; m_cnt = n_cnt; m_sel = n_sel; m_vis = n_vis; m_dirty = n_dirty;

        e.regs = '0;
        for (int i = 0; i < NUM_REGS; i++) e.regs[32*i +: 32] = m_dp[i];
        e.commit = m_commit; e.mode = m_mode; e.sel = m_sel; e.vis = m_vis; e.dirty = m_dirty;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("sb_regs",   disp_regs,        got.regs);
        check("sb_commit", W'(frame_commit), W'(got.commit));
        check("sb_mode",   W'(mode),         W'(got.mode));
        check("sb_sel",    W'(score_sel),    W'(got.sel));
        check("sb_vis",    W'(score_visible),W'(got.vis));
        check("sb_dirty",  W'(dirty),        W'(got.dirty));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic commit_idle();
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
        idle();
        idle();
    endtask

    initial begin
        reset = 1'b1; screen_end = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = 4'd0; reg_wr_data = 32'd0;

        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        check("rst_regs", disp_regs, '0);
        check("rst_mode", W'(mode), W'(2'd0));
        check("rst_sel",  W'(score_sel), W'(1'b1));
        check("rst_vis",  W'(score_visible), W'(1'b1));

        // Write reg 13 without a frame boundary
        step(1'b0, 1'b0, 1'b1, 4'd13, 32'd5);
`ifdef VGA_DOUBLE_BUFFER_EN
        check("pre_commit_r13", W'(disp_regs[32*13 +: 32]), W'(32'd0));
        check("pre_commit_dirty", W'(dirty), W'(1'b1));
`else
        check("direct_r13", W'(disp_regs[32*13 +: 32]), W'(32'd5));
`endif
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
        check("commit_r13", W'(disp_regs[32*13 +: 32]), W'(32'd5));
        check("commit_pulse", W'(frame_commit), W'(1'b1));
        check("commit_dirty", W'(dirty), W'(1'b0));
        idle();
        idle();

        // Write coincident with screen_end is included in the commit
        step(1'b0, 1'b1, 1'b1, 4'd0, 32'h40);
        check("same_cycle_r0", W'(disp_regs[31:0]), W'(32'h40));
        idle();
        check("playing", W'(mode), W'(2'd1));
        check("playing_sel", W'(score_sel), W'(1'b0));

        // Clear everything -> GAMEOVER
        for (int i = 0; i < NUM_REGS; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 32'd0);
        commit_idle();
        check("gameover", W'(mode), W'(2'd2));

        for (int k = 1; k <= HOLD_FRAMES; k++) begin
            commit_idle();
            if (k == 1 || k == 15 || k == 16 || k == 30 || k == 31 || k == 45)
                check("blink", W'(score_visible), W'((k <= 15 || k > 30) ? 1'b1 : 1'b0));
            if (k == HOLD_FRAMES - 1) check("hold_not_yet", W'(mode), W'(2'd2));
        end
        check("hold_splash", W'(mode), W'(2'd0));
        check("hold_sel", W'(score_sel), W'(1'b1));

        // Back-to-back commits from SPLASH
        step(1'b0, 1'b1, 1'b1, 4'd13, 32'd1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
        check("b2b_commit", W'(frame_commit), W'(1'b1));
        idle();
        idle();
        check("b2b_playing", W'(mode), W'(2'd1));

        // GAMEOVER then reactivation at commit 50
        step(1'b0, 1'b1, 1'b1, 4'd13, 32'd0);
        idle();
        idle();
        check("gameover2", W'(mode), W'(2'd2));
        for (int k = 1; k < 50; k++) commit_idle();
        step(1'b0, 1'b1, 1'b1, 4'd12, 32'd100);
        idle();
        idle();
        check("reactivate", W'(mode), W'(2'd1));

        // Reset during GAMEOVER at commit 90 with a pending write
        step(1'b0, 1'b1, 1'b1, 4'd12, 32'd0);
        idle();
        idle();
        for (int k = 1; k <= 90; k++) commit_idle();
        check("pre_reset_go", W'(mode), W'(2'd2));
        step(1'b0, 1'b0, 1'b1, 4'd5, 32'd7);
        step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
        check("mid_rst_mode", W'(mode), W'(2'd0));
        check("mid_rst_regs", disp_regs, '0);
        commit_idle();
        check("discarded_write", disp_regs, '0);

        // Index 15 is ignored
        step(1'b0, 1'b1, 1'b1, 4'd15, 32'hDEAD);
        idle();
        check("addr15_ignored", disp_regs, '0);
        check("addr15_splash", W'(mode), W'(2'd0));

        step(1'b0, 1'b0, 1'b1, 4'd14, 32'd9);
`ifdef VGA_DOUBLE_BUFFER_EN
        check("r14_staged", W'(disp_regs[32*14 +: 32]), W'(32'd0));
        check("r14_dirty", W'(dirty), W'(1'b1));
`else
        check("r14_direct", W'(disp_regs[32*14 +: 32]), W'(32'd9));
        check("r14_dirty", W'(dirty), W'(1'b0));
`endif
        commit_idle();
        check("r14_final", W'(disp_regs[32*14 +: 32]), W'(32'd9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
